// File: rtl/layer_priority_mux_pkg.sv
// Shared defaults, colour type and width helper for the layer priority mux.
package layer_mux_pkg;

  localparam int RGB_W_DEF = 8;
  localparam logic [RGB_W_DEF-1:0] TRANSP_RGB_DEF = 8'hFF;
  localparam int NUM_LAYERS_DEF = 14;
  localparam int BLINK_FRAMES_DEF = 16;

  typedef logic [RGB_W_DEF-1:0] rgb_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_priority_mux_if.sv
// Pixel/layer bus between the object drawers and the layer priority mux.
interface layer_priority_mux_if
  import layer_mux_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int RGB_W      = RGB_W_DEF
);

  localparam int IDX_W = idxWidth(NUM_LAYERS);

  logic                  pixValidIn;
  logic [NUM_LAYERS-1:0] drawReq;
  logic [RGB_W-1:0]      layerRGB [NUM_LAYERS];
  logic [RGB_W-1:0]      bgRGB;
  logic                  cfgWe;
  logic [NUM_LAYERS-1:0] cfgEnableMask;
  logic                  startOfFrame;
  logic [NUM_LAYERS-1:0] blinkMask;
  logic [RGB_W-1:0]      RGBOut;
  logic                  pixValidOut;
  logic                  hitValid;
  logic [IDX_W-1:0]      hitIndex;

  modport master (
    output pixValidIn, drawReq, layerRGB, bgRGB, cfgWe, cfgEnableMask,
           startOfFrame, blinkMask,
    input  RGBOut, pixValidOut, hitValid, hitIndex
  );

  modport slave (
    input  pixValidIn, drawReq, layerRGB, bgRGB, cfgWe, cfgEnableMask,
           startOfFrame, blinkMask,
    output RGBOut, pixValidOut, hitValid, hitIndex
  );

endinterface

// File: rtl/layer_priority_mux_enc.sv
// Combinational priority encoder: lowest set request index wins.
module layer_prio_enc
  import layer_mux_pkg::*;
#(
  parameter int N     = NUM_LAYERS_DEF,
  parameter int IDX_W = idxWidth(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest index overwrites last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// Two-stage N-layer priority mux with enable mask and colour key.
// Optional layer blinking is built when LAYER_BLINK_EN is defined.
module layer_priority_mux
  import layer_mux_pkg::*;
#(
  parameter int               NUM_LAYERS   = NUM_LAYERS_DEF,
  parameter int               RGB_W        = RGB_W_DEF,
  parameter logic [RGB_W-1:0] TRANSP_RGB   = RGB_W'(TRANSP_RGB_DEF),
  parameter int               BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input logic clk,
  input logic resetN,
  layer_priority_mux_if.slave bus
);

  localparam int IDX_W = idxWidth(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] enMask;
  logic [NUM_LAYERS-1:0] blanked;
  logic [NUM_LAYERS-1:0] eligible;
  logic [IDX_W-1:0]      encIdx;
  logic                  encAny;

  logic                  s1Valid;
  logic                  s1Any;
  logic [IDX_W-1:0]      s1Idx;
  logic [RGB_W-1:0]      s1RGB;

  // New mask applies from the next sampled pixel onwards.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      enMask <= '1;
    end else if (bus.cfgWe) begin
      enMask <= bus.cfgEnableMask;
    end
  end

`ifdef LAYER_BLINK_EN
  localparam int CNT_W = idxWidth(BLINK_FRAMES);

  logic [CNT_W-1:0] frameCnt;
  logic             phase;

  // Phase 0 shows blinking layers, phase 1 hides them.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      frameCnt <= '0;
      phase    <= 1'b0;
    end else if (bus.startOfFrame) begin
      if (frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frameCnt <= '0;
        phase    <= ~phase;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

  assign blanked = bus.blinkMask & {NUM_LAYERS{phase}};
`else
  logic unusedBlinkInputs;

  assign unusedBlinkInputs = ^{bus.blinkMask, bus.startOfFrame};
  assign blanked           = '0;
`endif

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eligible[i] = bus.drawReq[i] & enMask[i] & ~blanked[i]
                  & (bus.layerRGB[i] != TRANSP_RGB);
    end
  end

  layer_prio_enc #(
    .N     (NUM_LAYERS),
    .IDX_W (IDX_W)
  ) u_enc (
    .req (eligible),
    .idx (encIdx),
    .any (encAny)
  );

  // Stage 1 always captures; the background travels with its own pixel.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1Valid <= 1'b0;
      s1Any   <= 1'b0;
      s1Idx   <= '0;
      s1RGB   <= '0;
    end else begin
      s1Valid <= bus.pixValidIn;
      s1Any   <= encAny;
      s1Idx   <= encIdx;
      s1RGB   <= encAny ? bus.layerRGB[encIdx] : bus.bgRGB;
    end
  end

  // Stage 2 only advances on valid pixels so outputs hold across gaps.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bus.RGBOut      <= '0;
      bus.pixValidOut <= 1'b0;
      bus.hitValid    <= 1'b0;
      bus.hitIndex    <= '0;
    end else begin
      bus.pixValidOut <= s1Valid;
      if (s1Valid) begin
        bus.RGBOut   <= s1RGB;
        bus.hitValid <= s1Any;
        bus.hitIndex <= s1Idx;
      end
    end
  end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux; blink test built with LAYER_BLINK_EN.
module tb_layer_priority_mux;

  localparam int N = 14;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  layer_priority_mux_if #(.NUM_LAYERS(N), .RGB_W(8)) bus ();

  layer_priority_mux #(.NUM_LAYERS(N), .RGB_W(8)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.pixValidIn    = 1'b0;
    bus.drawReq       = '0;
    bus.bgRGB         = 8'h00;
    bus.cfgWe         = 1'b0;
    bus.cfgEnableMask = '1;
    bus.startOfFrame  = 1'b0;
    bus.blinkMask     = '0;
    for (int i = 0; i < N; i++) bus.layerRGB[i] = 8'h00;
  endtask

  task automatic test_reset();
    clearInputs();
    resetN         = 1'b0;
    bus.pixValidIn = 1'b1;
    bus.drawReq    = '1;
    for (int i = 0; i < N; i++) bus.layerRGB[i] = 8'h40 + 8'(i);
    repeat (3) tick();
    checks++; if (bus.RGBOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 00", bus.RGBOut); end
    checks++; if (bus.pixValidOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_pv: got %b expected 0", bus.pixValidOut); end
    checks++; if (bus.hitValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_hv: got %b expected 0", bus.hitValid); end
    checks++; if (bus.hitIndex !== 4'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", bus.hitIndex); end
    clearInputs();
    resetN         = 1'b1;
    bus.pixValidIn = 1'b1;
    bus.drawReq    = 14'b10_0000_0000_0001;
    bus.layerRGB[0]  = 8'h55;
    bus.layerRGB[13] = 8'h66;
    tick();
    bus.pixValidIn = 1'b0;
    checks++; if (bus.pixValidOut !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_lat1: got %b expected 0", bus.pixValidOut); end
    tick();
    checks++; if (bus.pixValidOut !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_lat2: got %b expected 1", bus.pixValidOut); end
    checks++; if (bus.RGBOut !== 8'h55) begin errors++; $display("[TB] FAIL post_reset_rgb: got %h expected 55", bus.RGBOut); end
    checks++; if (bus.hitIndex !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_idx: got %0d expected 0", bus.hitIndex); end
    checks++; if (bus.hitValid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_hv: got %b expected 1", bus.hitValid); end
  endtask

  task automatic test_priority();
    clearInputs();
    bus.pixValidIn  = 1'b1;
    bus.drawReq     = 14'b00_0000_0000_0110;
    bus.layerRGB[1] = 8'h1C;
    bus.layerRGB[2] = 8'hE0;
    tick();
    bus.pixValidIn = 1'b0;
    tick();
    checks++; if (bus.RGBOut !== 8'h1C) begin errors++; $display("[TB] FAIL prio_rgb: got %h expected 1c", bus.RGBOut); end
    checks++; if (bus.hitIndex !== 4'd1) begin errors++; $display("[TB] FAIL prio_idx: got %0d expected 1", bus.hitIndex); end
    checks++; if (bus.hitValid !== 1'b1) begin errors++; $display("[TB] FAIL prio_hv: got %b expected 1", bus.hitValid); end
  endtask

  task automatic test_transparency();
    clearInputs();
    bus.pixValidIn  = 1'b1;
    bus.drawReq     = 14'b00_0000_0000_1001;
    bus.layerRGB[0] = 8'hFF;
    bus.layerRGB[3] = 8'h03;
    tick();
    bus.pixValidIn = 1'b0;
    tick();
    checks++; if (bus.RGBOut !== 8'h03) begin errors++; $display("[TB] FAIL transp_rgb: got %h expected 03", bus.RGBOut); end
    checks++; if (bus.hitIndex !== 4'd3) begin errors++; $display("[TB] FAIL transp_idx: got %0d expected 3", bus.hitIndex); end
  endtask

  task automatic test_mask();
    clearInputs();
    bus.pixValidIn    = 1'b1;
    bus.drawReq       = '1;
    bus.bgRGB         = 8'h92;
    bus.layerRGB[0]   = 8'hFF;
    bus.layerRGB[1]   = 8'h2A;
    bus.cfgWe         = 1'b1;
    bus.cfgEnableMask = '0;
    tick();
    bus.cfgWe = 1'b0;
    tick();
    bus.pixValidIn = 1'b0;
    checks++; if (bus.RGBOut !== 8'h2A) begin errors++; $display("[TB] FAIL mask_same_edge_rgb: got %h expected 2a", bus.RGBOut); end
    checks++; if (bus.hitIndex !== 4'd1) begin errors++; $display("[TB] FAIL mask_same_edge_idx: got %0d expected 1", bus.hitIndex); end
    tick();
    checks++; if (bus.RGBOut !== 8'h92) begin errors++; $display("[TB] FAIL mask_bg_rgb: got %h expected 92", bus.RGBOut); end
    checks++; if (bus.hitValid !== 1'b0) begin errors++; $display("[TB] FAIL mask_bg_hv: got %b expected 0", bus.hitValid); end
    checks++; if (bus.hitIndex !== 4'd0) begin errors++; $display("[TB] FAIL mask_bg_idx: got %0d expected 0", bus.hitIndex); end
    bus.cfgWe         = 1'b1;
    bus.cfgEnableMask = '1;
    tick();
    bus.cfgWe = 1'b0;
    tick();
  endtask

  task automatic test_valid_gating();
    clearInputs();
    bus.pixValidIn  = 1'b1;
    bus.drawReq     = 14'b00_0000_0000_0100;
    bus.layerRGB[2] = 8'h12;
    tick();
    bus.pixValidIn  = 1'b0;
    bus.drawReq     = 14'b00_0000_0001_0000;
    bus.layerRGB[4] = 8'h34;
    tick();
    bus.pixValidIn  = 1'b1;
    bus.drawReq     = 14'b00_0000_0100_0000;
    bus.layerRGB[6] = 8'h56;
    checks++; if (bus.pixValidOut !== 1'b1 || bus.RGBOut !== 8'h12) begin errors++; $display("[TB] FAIL gate_slot0: got pv=%b rgb=%h expected pv=1 rgb=12", bus.pixValidOut, bus.RGBOut); end
    tick();
    bus.pixValidIn = 1'b0;
    checks++; if (bus.pixValidOut !== 1'b0 || bus.RGBOut !== 8'h12 || bus.hitIndex !== 4'd2) begin errors++; $display("[TB] FAIL gate_slot1_hold: got pv=%b rgb=%h idx=%0d expected pv=0 rgb=12 idx=2", bus.pixValidOut, bus.RGBOut, bus.hitIndex); end
    tick();
    checks++; if (bus.pixValidOut !== 1'b1 || bus.RGBOut !== 8'h56 || bus.hitIndex !== 4'd6) begin errors++; $display("[TB] FAIL gate_slot2: got pv=%b rgb=%h idx=%0d expected pv=1 rgb=56 idx=6", bus.pixValidOut, bus.RGBOut, bus.hitIndex); end
    tick();
    checks++; if (bus.pixValidOut !== 1'b0) begin errors++; $display("[TB] FAIL gate_tail_pv: got %b expected 0", bus.pixValidOut); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expRGB [3];
    logic [3:0] expIdx [3];
    logic       expHv  [3];
    expRGB = '{8'h35, 8'h44, 8'hD0};
    expIdx = '{4'd5, 4'd0, 4'd13};
    expHv  = '{1'b1, 1'b0, 1'b1};
    clearInputs();
    bus.pixValidIn = 1'b1;
    bus.drawReq = 14'b00_0000_0010_0000; bus.layerRGB[5] = 8'h35; bus.bgRGB = 8'h11;
    tick();
    bus.drawReq = '0; bus.bgRGB = 8'h44;
    tick();
    bus.drawReq = 14'b10_0000_0000_0000; bus.layerRGB[13] = 8'hD0; bus.bgRGB = 8'h77;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        checks++; if (bus.RGBOut !== expRGB[k] || bus.hitIndex !== expIdx[k] || bus.hitValid !== expHv[k]) begin errors++; $display("[TB] FAIL b2b_%0d: got rgb=%h idx=%0d hv=%b expected rgb=%h idx=%0d hv=%b", k, bus.RGBOut, bus.hitIndex, bus.hitValid, expRGB[k], expIdx[k], expHv[k]); end
      end else begin
        tick();
        bus.pixValidIn = 1'b0;
        checks++; if (bus.RGBOut !== expRGB[k] || bus.hitIndex !== expIdx[k] || bus.hitValid !== expHv[k] || bus.pixValidOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_%0d: got rgb=%h idx=%0d hv=%b pv=%b expected rgb=%h idx=%0d hv=%b pv=1", k, bus.RGBOut, bus.hitIndex, bus.hitValid, bus.pixValidOut, expRGB[k], expIdx[k], expHv[k]); end
      end
    end
  endtask

`ifdef LAYER_BLINK_EN
  task automatic test_blink();
    clearInputs();
    bus.blinkMask   = 14'b00_0000_0000_0001;
    bus.drawReq     = 14'b00_0000_0000_0011;
    bus.layerRGB[0] = 8'hAA;
    bus.layerRGB[1] = 8'hBB;
    for (int half = 0; half < 3; half++) begin
      bus.pixValidIn = 1'b1;
      tick();
      bus.pixValidIn = 1'b0;
      tick();
      if (half == 1) begin
        checks++; if (bus.RGBOut !== 8'hBB || bus.hitIndex !== 4'd1) begin errors++; $display("[TB] FAIL blink_hidden: got rgb=%h idx=%0d expected rgb=bb idx=1", bus.RGBOut, bus.hitIndex); end
      end else begin
        checks++; if (bus.RGBOut !== 8'hAA || bus.hitIndex !== 4'd0) begin errors++; $display("[TB] FAIL blink_visible_%0d: got rgb=%h idx=%0d expected rgb=aa idx=0", half, bus.RGBOut, bus.hitIndex); end
      end
      if (half < 2) begin
        for (int f = 0; f < 16; f++) begin
          bus.startOfFrame = 1'b1;
          tick();
          bus.startOfFrame = 1'b0;
          tick();
        end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    resetN = 1'b0;
    test_reset();
    test_priority();
    test_transparency();
    test_mask();
    test_valid_gating();
    test_back_to_back();
`ifdef LAYER_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
